// File: rtl/cla_pipe_adder.sv
`timescale 1ns/1ps
// Pipelined carry-lookahead adder/subtractor with valid/ready handshake on both sides.
// Group carries resolve across STAGES registered stages behind an input register; the pipeline stalls as a whole.
module cla_pipe_adder #(
    parameter int WIDTH  = 32,
    parameter int BLOCK  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int NG = WIDTH / BLOCK;

    generate
        if ((WIDTH % BLOCK) != 0 || STAGES < 1 || STAGES > NG) begin : g_param_check
            $error("cla_pipe_adder: WIDTH must be a multiple of BLOCK and 1 <= STAGES <= WIDTH/BLOCK");
        end
    endgenerate

    // Pipeline stage (1..STAGES) in which group k resolves its carry-in and sum bits.
    function automatic int group_stage(input int k);
        return 1 + (k * STAGES) / NG;
    endfunction

    function automatic logic group_gen(input logic [BLOCK-1:0] p, input logic [BLOCK-1:0] g);
        logic gg;
        gg = 1'b0;
        for (int i = 0; i < BLOCK; i++) begin
            gg = g[i] | (p[i] & gg);
        end
        return gg;
    endfunction

    logic                 en;
    logic [STAGES:0]      valid_reg;
    logic [WIDTH-1:0]     a_reg;
    logic [WIDTH-1:0]     bx_reg;
    logic                 c0_reg;

    logic [WIDTH-1:0]     p0;
    logic [WIDTH-1:0]     g0;
    logic [NG-1:0]        pg0;
    logic [NG-1:0]        gg0;

    logic [WIDTH-1:0]     p_reg  [1:STAGES];
    logic [WIDTH-1:0]     g_reg  [1:STAGES];
    logic [NG-1:0]        pg_reg [1:STAGES];
    logic [NG-1:0]        gg_reg [1:STAGES];
    logic [WIDTH-1:0]     s_reg  [1:STAGES];
    logic [STAGES:1]      c_reg;
    logic                 ovf_reg;
    logic                 zero_reg;

    logic [WIDTH-1:0]     src_p  [1:STAGES];
    logic [WIDTH-1:0]     src_g  [1:STAGES];
    logic [NG-1:0]        src_pg [1:STAGES];
    logic [NG-1:0]        src_gg [1:STAGES];
    logic [WIDTH-1:0]     src_s  [1:STAGES];
    logic [STAGES:1]      src_c;

    logic [WIDTH-1:0]     s_next [1:STAGES];
    logic [STAGES:1]      c_next;
    logic                 ovf_next;

    assign en        = out_ready | ~valid_reg[STAGES];
    assign in_ready  = en;
    assign out_valid = valid_reg[STAGES];
    assign sum       = s_reg[STAGES];
    assign cout      = c_reg[STAGES];
    assign ovf       = ovf_reg;
    assign zero      = zero_reg;

    assign p0 = a_reg ^ bx_reg;
    assign g0 = a_reg & bx_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NG; gi++) begin : g_group
            assign pg0[gi] = &p0[gi*BLOCK +: BLOCK];
            assign gg0[gi] = group_gen(p0[gi*BLOCK +: BLOCK], g0[gi*BLOCK +: BLOCK]);
        end

        // Stage 1 works from the input register; later stages from their predecessor.
        for (gi = 1; gi <= STAGES; gi++) begin : g_src
            if (gi == 1) begin : g_first
                assign src_p[gi]  = p0;
                assign src_g[gi]  = g0;
                assign src_pg[gi] = pg0;
                assign src_gg[gi] = gg0;
                assign src_s[gi]  = '0;
                assign src_c[gi]  = c0_reg;
            end else begin : g_chain
                assign src_p[gi]  = p_reg[gi-1];
                assign src_g[gi]  = g_reg[gi-1];
                assign src_pg[gi] = pg_reg[gi-1];
                assign src_gg[gi] = gg_reg[gi-1];
                assign src_s[gi]  = s_reg[gi-1];
                assign src_c[gi]  = c_reg[gi-1];
            end
        end
    endgenerate

    always_comb begin
        logic [WIDTH-1:0] cur_s;
        logic             cur_c;
        logic             bit_c;
        logic             msb_c;
        cur_s  = '0;
        cur_c  = 1'b0;
        bit_c  = 1'b0;
        msb_c  = 1'b0;
        s_next = src_s;
        c_next = src_c;
        for (int s = 1; s <= STAGES; s++) begin
            cur_s = src_s[s];
            cur_c = src_c[s];
            for (int k = 0; k < NG; k++) begin
                if (group_stage(k) == s) begin
                    bit_c = cur_c;
                    for (int i = 0; i < BLOCK; i++) begin
                        // The last group always lands in the final stage, so the MSB carry-in is final here.
                        if (k * BLOCK + i == WIDTH - 1) msb_c = bit_c;
                        cur_s[k*BLOCK+i] = src_p[s][k*BLOCK+i] ^ bit_c;
                        bit_c = src_g[s][k*BLOCK+i] | (src_p[s][k*BLOCK+i] & bit_c);
                    end
                    cur_c = src_gg[s][k] | (src_pg[s][k] & cur_c);
                end
            end
            s_next[s] = cur_s;
            c_next[s] = cur_c;
        end
        ovf_next = msb_c ^ c_next[STAGES];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_reg <= '0;
            a_reg     <= '0;
            bx_reg    <= '0;
            c0_reg    <= 1'b0;
            c_reg     <= '0;
            ovf_reg   <= 1'b0;
            zero_reg  <= 1'b0;
            for (int s = 1; s <= STAGES; s++) begin
                p_reg[s]  <= '0;
                g_reg[s]  <= '0;
                pg_reg[s] <= '0;
                gg_reg[s] <= '0;
                s_reg[s]  <= '0;
            end
        end else if (en) begin
            valid_reg <= {valid_reg[STAGES-1:0], in_valid};
            a_reg     <= a;
            bx_reg    <= sub ? ~b : b;
            c0_reg    <= sub | cin;
            c_reg     <= c_next;
            ovf_reg   <= ovf_next;
            zero_reg  <= ~|s_next[STAGES];
            for (int s = 1; s <= STAGES; s++) begin
                p_reg[s]  <= src_p[s];
                g_reg[s]  <= src_g[s];
                pg_reg[s] <= src_pg[s];
                gg_reg[s] <= src_gg[s];
                s_reg[s]  <= s_next[s];
            end
        end
    end

endmodule
